multdiv: RTL and testbench
==========================

Name: multdiv

Overview:
- Multi-cycle signed 32-bit multiply/divide unit on the execute path.
- Consumes operand pairs read from the register file (ports A and B).
- Its result is written back into the register file by the writeback logic.
- Runs iteratively, one bit per clock, so the pipeline stalls on busy and writes back on data_resultRDY.

Parameters:
- WIDTH, 32, operand/result width; the bench uses only 32.
- ITERS, WIDTH, iteration count, one per clock.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- ctrl_reset  input  1  asynchronous, active-high reset.
- ctrl_MULT  input  1  start signed multiply; sampled on posedge.
- ctrl_DIV  input  1  start signed divide; sampled on posedge.
- data_operandA  input  WIDTH  multiplicand / dividend; sampled on the start edge only.
- data_operandB  input  WIDTH  multiplier / divisor; sampled on the start edge only.
- data_result  output  WIDTH  product (low WIDTH bits) or quotient.
- data_exception  output  1  overflow or divide-by-zero flag; valid while data_resultRDY=1.
- data_resultRDY  output  1  one-cycle completion pulse.
- busy  output  1  high from the cycle after the start edge until data_resultRDY falls.

Behaviour:
- Clock and reset are decided: one clock, named clock; reset is asynchronous and active-high, named ctrl_reset.
- Reset values: data_result=0, data_exception=0, data_resultRDY=0, busy=0, FSM=IDLE, counter=0, operand registers=0.
- FSM states:
  - IDLE, MUL, DIV, DONE.
  - IDLE -> MUL on ctrl_MULT=1 at an edge; IDLE -> DIV on ctrl_DIV=1 at an edge.
  - MUL/DIV -> DONE when the counter reaches ITERS-1.
  - DONE -> IDLE unconditionally after one cycle.
- Start edge E0:
  - Latch operands and opcode, clear the counter, set busy.
  - If both ctrl_MULT and ctrl_DIV are high, multiply wins.
- Starts received in MUL, DIV or DONE are ignored, with no queuing; operand changes during an operation have no effect.
- Multiply:
  - Radix-2 Booth, one step per edge E1..E32.
  - 2*WIDTH+1-bit accumulator with arithmetic right shift.
  - data_result = low WIDTH bits of the 64-bit signed product.
  - data_exception=1 iff the upper 32 bits are not all equal to bit 31 of the product.
- Divide:
  - Non-restoring division on operand magnitudes, one step per edge.
  - Final sign fix-up: quotient negated iff the operand signs differ; truncation is toward zero; the remainder is discarded.
  - Divisor 0: result 0, exception 1.
  - 0x80000000 / 0xFFFFFFFF: result 0x80000000, exception 1.
  - Otherwise exception 0.
- Latency:
  - Result, exception and data_resultRDY register at edge E33, i.e. ITERS+1 edges after the start.
  - data_resultRDY is high for exactly the cycle following E33.
  - busy falls at E34, together with data_resultRDY.
- Output hold: data_result and data_exception hold their values after DONE until the next completion; they never glitch mid-operation.
- Back-to-back operation: a new start is accepted at E34, the first edge back in IDLE.
- Reset mid-operation: abort immediately, return all outputs to reset values, and suppress the pending data_resultRDY.
- Counter: log2(ITERS)+1 bits; never wraps within an operation.

Decomposition:
- Package multdiv_pkg holds:
  - the WIDTH constant;
  - the state encoding (IDLE=2'd0, MUL=2'd1, DIV=2'd2, DONE=2'd3);
  - the opcode constants (OP_MUL, OP_DIV);
  - the INT_MIN constant 32'h80000000.
- One natural sub-module, multdiv_ctrl: the FSM, iteration counter, busy/ready generation and start arbitration.
- Booth and divider datapaths stay in the top module.

Test Plan:
1. Multiply: ctrl_MULT pulse with A=7, B=0xFFFFFFFD (-3) -> exactly 33 edges later data_resultRDY=1 for one cycle, data_result=0xFFFFFFEB, exception=0; busy high 34 cycles.
2. Multiply overflow: A=0x00010000, B=0x00010000 -> data_result=0x00000000, exception=1; A=0x80000000, B=1 -> 0x80000000, exception=0.
3. Divide: ctrl_DIV with A=0xFFFFFF9C (-100), B=7 -> data_result=0xFFFFFFF2 (-14), exception=0.
4. Divide corner cases:
   - A=5, B=0 -> result=0, exception=1.
   - A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=1.
   - A=0, B=9 -> result=0, exception=0.
5. Protocol:
   - Assert ctrl_DIV at cycle 5 of an active multiply with new operands -> ignored; the original product is returned at cycle 33, then the unit returns to idle.
   - Assert both starts together -> the multiply result is returned.
6. Reset: assert ctrl_reset asynchronously mid-clock at cycle 10 of a divide -> all outputs 0 immediately; no data_resultRDY pulse within 40 cycles; a following 3*4 returns 12.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared constants and encodings for the multi-cycle multiply/divide unit.
package multdiv_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/multdiv_ctrl.sv
// Sequencer for multdiv: start arbitration, iteration counter, busy/ready.
//  state | meaning
//  IDLE  | waiting for ctrl_MULT / ctrl_DIV (multiply wins a tie)
//  MUL   | one Booth step per clock
//  DIV   | one non-restoring step per clock
//  DONE  | results registered this edge; ready pulses next cycle
module multdiv_ctrl #(
    parameter int ITERS = 32
) (
    input  logic clock,
    input  logic ctrl_reset,
    input  logic i_mult,
    input  logic i_div,
    output logic o_start,
    output logic o_start_mul,
    output logic o_step_mul,
    output logic o_step_div,
    output logic o_finish,
    output logic o_busy,
    output logic o_rdy
);
    import multdiv_pkg::*;

    localparam int CW = $clog2(ITERS) + 1;
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic            w_last;

    assign w_last     = (r_cnt == LAST);
    assign o_step_mul = (r_state == MUL);
    assign o_step_div = (r_state == DIV);
    assign o_finish   = (r_state == DONE);

    always_comb begin
        w_next      = r_state;
        o_start     = 1'b0;
        o_start_mul = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_mult || i_div) begin
                    o_start     = 1'b1;
                    o_start_mul = i_mult;
                    w_next      = i_mult ? MUL : DIV;
                end
            end
            MUL, DIV: begin
                if (w_last)
                    w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            o_busy  <= 1'b0;
            o_rdy   <= 1'b0;
        end else begin
            r_state <= w_next;
            o_rdy   <= (r_state == DONE);
            if (o_start)
                r_cnt <= '0;
            else if (o_step_mul || o_step_div)
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            // A start on the ready cycle keeps busy high without a gap
            if (o_start)
                o_busy <= 1'b1;
            else if (o_rdy)
                o_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/multdiv.sv
// Iterative signed multiply (radix-2 Booth) / divide (non-restoring) unit.
// Results register one edge after the last iteration and then hold.
module multdiv #(
    parameter int WIDTH = 32,
    parameter int ITERS = WIDTH
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    import multdiv_pkg::*;

    logic               w_start, w_start_mul, w_step_mul, w_step_div, w_finish;
    logic [WIDTH-1:0]   r_opa, r_opb;
    logic               r_op;
    logic [2*WIDTH:0]   r_acc;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quo;

    multdiv_ctrl #(.ITERS(ITERS)) u_ctrl (
        .clock       (clock),
        .ctrl_reset  (ctrl_reset),
        .i_mult      (ctrl_MULT),
        .i_div       (ctrl_DIV),
        .o_start     (w_start),
        .o_start_mul (w_start_mul),
        .o_step_mul  (w_step_mul),
        .o_step_div  (w_step_div),
        .o_finish    (w_finish),
        .o_busy      (busy),
        .o_rdy       (data_resultRDY)
    );

    // Booth add is one bit wider than the upper half so -INT_MIN cannot wrap
    logic [WIDTH:0]     w_upper, w_mext, w_sum;
    assign w_upper = {r_acc[2*WIDTH], r_acc[2*WIDTH:WIDTH+1]};
    assign w_mext  = {r_opa[WIDTH-1], r_opa};

    always_comb begin
        case (r_acc[1:0])
            2'b01:   w_sum = w_upper + w_mext;
            2'b10:   w_sum = w_upper - w_mext;
            default: w_sum = w_upper;
        endcase
    end

    logic [WIDTH-1:0]   w_abs_a, w_dvs;
    logic [WIDTH:0]     w_rem_sh, w_dext, w_rem_nx;
    assign w_abs_a  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign w_dvs    = r_opb[WIDTH-1] ? -r_opb : r_opb;
    assign w_dext   = {1'b0, w_dvs};
    // Partial remainder always lies in [-D, D), so modulo 2^(WIDTH+1) is exact
    assign w_rem_sh = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_rem_nx = r_rem[WIDTH] ? (w_rem_sh + w_dext) : (w_rem_sh - w_dext);

    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo_s, w_res;
    logic               w_mul_exc, w_exc;
    assign w_prod    = r_acc[2*WIDTH:1];
    assign w_mul_exc = !((&w_prod[2*WIDTH-1:WIDTH-1]) || !(|w_prod[2*WIDTH-1:WIDTH-1]));
    assign w_quo_s   = (r_opa[WIDTH-1] ^ r_opb[WIDTH-1]) ? -r_quo : r_quo;

    always_comb begin
        w_res = '0;
        w_exc = 1'b0;
        if (r_op == OP_MUL) begin
            w_res = w_prod[WIDTH-1:0];
            w_exc = w_mul_exc;
        end else if (r_opb == '0) begin
            w_res = '0;
            w_exc = 1'b1;
        end else if ((r_opa == INT_MIN) && (&r_opb)) begin
            w_res = INT_MIN;
            w_exc = 1'b1;
        end else begin
            w_res = w_quo_s;
        end
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_opa          <= '0;
            r_opb          <= '0;
            r_op           <= OP_MUL;
            r_acc          <= '0;
            r_rem          <= '0;
            r_quo          <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else begin
            if (w_start) begin
                r_opa <= data_operandA;
                r_opb <= data_operandB;
                r_op  <= w_start_mul ? OP_MUL : OP_DIV;
                r_acc <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
                r_rem <= '0;
                r_quo <= w_abs_a;
            end else if (w_step_mul) begin
                r_acc <= {w_sum, r_acc[WIDTH:1]};
            end else if (w_step_div) begin
                r_rem <= w_rem_nx;
                r_quo <= {r_quo[WIDTH-2:0], ~w_rem_nx[WIDTH]};
            end
            if (w_finish) begin
                data_result    <= w_res;
                data_exception <= w_exc;
            end
        end
    end

endmodule

// File: tb/tb_multdiv.sv
// Directed self-checking bench for multdiv: latency, results, exceptions,
// start arbitration, back-to-back starts and asynchronous reset abort.
module tb_multdiv;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    multdiv #(.WIDTH(32), .ITERS(32)) dut (
        .clock          (clock),
        .ctrl_reset     (ctrl_reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive a start for one edge (E0), then scramble operands.
    task automatic start(input logic mul, input logic div, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        @(negedge clock);
        ctrl_MULT     = mul;
        ctrl_DIV      = div;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        chk({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
    endtask

    // Wait for ready, counting edges since E0 (n0 already elapsed).
    task automatic wait_done(input string tag, input int n0, input logic [31:0] er, input logic ee);
        int          n      = n0;
        int          glitch = 0;
        logic [31:0] held   = data_result;
        while (data_resultRDY !== 1'b1 && n < 40) begin
            @(posedge clock);
            #1;
            n++;
            if (data_resultRDY !== 1'b1 && data_result !== held)
                glitch++;
        end
        chk({tag, "_latency"}, n, 32'd33);
        chk({tag, "_result"}, data_result, er);
        chk({tag, "_exc"}, {31'd0, data_exception}, {31'd0, ee});
        chk({tag, "_busy_rdy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_hold"}, glitch, 32'd0);
    endtask

    task automatic idle_chk(input string tag);
        @(posedge clock);
        #1;
        chk({tag, "_rdy_fall"}, {31'd0, data_resultRDY}, 32'd0);
        chk({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_op(input logic mul, input logic div, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ee, input string tag);
        start(mul, div, a, b, tag);
        wait_done(tag, 0, er, ee);
        idle_chk(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        ctrl_reset    = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        #12;
        chk("reset_result", data_result, 32'd0);
        chk("reset_exc", {31'd0, data_exception}, 32'd0);
        chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        ctrl_reset = 1'b0;

        // 7 * -3, then a start on the ready cycle (accepted at E34)
        start(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, "mul_7x-3");
        wait_done("mul_7x-3", 0, 32'hFFFF_FFEB, 1'b0);
        ctrl_MULT     = 1'b1;
        data_operandA = 32'h0001_0000;
        data_operandB = 32'h0001_0000;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_rdy", {31'd0, data_resultRDY}, 32'd0);
        wait_done("mul_ovf_2^32", 0, 32'h0000_0000, 1'b1);
        idle_chk("mul_ovf_2^32");

        run_op(1'b1, 1'b0, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0, "mul_min_x1");
        run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, "mul_min_xmin");
        run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "mul_-1x-1");

        run_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 1'b0, "div_-100/7");
        run_op(1'b0, 1'b1, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, "div_100/-7");
        run_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 1'b0, "div_-100/-7");
        run_op(1'b0, 1'b1, 32'd5,         32'd0,         32'h0000_0000, 1'b1, "div_5/0");
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_min/-1");
        run_op(1'b0, 1'b1, 32'd0,         32'd9,         32'h0000_0000, 1'b0, "div_0/9");
        run_op(1'b0, 1'b1, 32'd7,         32'hFFFF_FF9C, 32'h0000_0000, 1'b0, "div_7/-100");
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'd2,         32'hC000_0000, 1'b0, "div_min/2");
        run_op(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, "div_max/min");

        // Divide request mid-multiply must be ignored
        start(1'b1, 1'b0, 32'd6, 32'd7, "ignore");
        repeat (4) begin
            @(posedge clock);
            #1;
        end
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd3;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        wait_done("ignore", 5, 32'd42, 1'b0);
        idle_chk("ignore");
        idle_chk("ignore_idle");

        run_op(1'b1, 1'b1, 32'd9, 32'hFFFF_FFFE, 32'hFFFF_FFEE, 1'b0, "both_starts");

        // Asynchronous reset mid-divide
        start(1'b0, 1'b1, 32'd1000, 32'd3, "reset_abort");
        repeat (9) begin
            @(posedge clock);
            #1;
        end
        #3;
        ctrl_reset = 1'b1;
        #1;
        chk("abort_result", data_result, 32'd0);
        chk("abort_exc", {31'd0, data_exception}, 32'd0);
        chk("abort_rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        ctrl_reset = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1 || busy === 1'b1)
                pulses++;
        end
        chk("abort_no_rdy", pulses, 32'd0);
        run_op(1'b1, 1'b0, 32'd3, 32'd4, 32'd12, 1'b0, "after_reset_3x4");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
